// File: rtl/mem_access_unit.sv
// Purpose : MEM stage of the pipeline. Turns EX load/store requests into a
//           single-beat data-memory transaction, with ALU pass-through and error
//           reporting.
// Latency : memory ops take 2+ cycles from presentation to write-back; ALU ops
//           and error pulses take 1 cycle.
// Backpressure: mem_stall holds IF/ID/EX from the accept cycle until the ack
//           cycle or the timeout cycle.
// Ports   : clk/rst (sync, active-high); ex_* request from EX; dmem_* memory
//           bus (req/we/addr/be/wdata out, ack/rdata in); mem_stall; mem_wb_*
//           write-back; mem_addr_err / mem_bus_err one-cycle error pulses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic [31:0] ex_mem_mem_addr,
  input  logic [31:0] ex_mem_store_data,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_load_signed,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_mem_regfile_we,
  input  logic [4:0]  ex_mem_regfile_waddr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_wb_regfile_we,
  output logic [4:0]  mem_wb_regfile_waddr,
  output logic [31:0] mem_wb_wdata,
  output logic        mem_addr_err,
  output logic        mem_bus_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Everything captured at accept time; bus lanes are pre-computed so the
  // dmem_* outputs come straight from flops and stay stable while BUSY.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic        is_store;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rf_we;
    logic [4:0]  waddr;
  } req_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;

  logic        aligned, access, bad_req, busy, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    case (ex_mem_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ex_mem_mem_addr[0];
      2'b10:   aligned = (ex_mem_mem_addr[1:0] == 2'b00);
      default: aligned = 1'b0;   // illegal size never counts as an access
    endcase
  end

  assign access      = (ex_mem_re ^ ex_mem_we) & aligned;
  assign bad_req     = (ex_mem_re | ex_mem_we) & ~access;
  assign busy        = (state_q == BUSY);
  // Last BUSY cycle allowed without ack; an ack in that same cycle still wins.
  assign timeout_hit = busy & ~dmem_ack & (cnt_q == CNT_LAST);

  // Store lane steering: replicate data across lanes, enable only the target.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    if (ex_mem_we) begin
      st_wdata = ex_mem_store_data;
      case (ex_mem_size)
        2'b00: begin
          st_be    = 4'b0001 << ex_mem_mem_addr[1:0];
          st_wdata = {4{ex_mem_store_data[7:0]}};
        end
        2'b01: begin
          st_be    = ex_mem_mem_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{ex_mem_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Little-endian load extraction from the registered address.
  always_comb begin
    case (req_q.addr[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = req_q.addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (req_q.size)
      2'b00:   ld_val = {{24{req_q.sgn & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{req_q.sgn & ld_half[15]}}, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    wb_we_d    = 1'b0;
    wb_waddr_d = '0;
    wb_wdata_d = '0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d        = BUSY;
          cnt_d          = '0;
          req_d.addr     = ex_mem_mem_addr;
          req_d.size     = ex_mem_size;
          req_d.sgn      = ex_mem_load_signed;
          req_d.is_store = ex_mem_we;
          req_d.be       = st_be;
          req_d.wdata    = st_wdata;
          req_d.rf_we    = ex_mem_regfile_we;
          req_d.waddr    = ex_mem_regfile_waddr;
        end else if (bad_req) begin
          addr_err_d = 1'b1;
        end else begin
          wb_we_d    = ex_mem_regfile_we;
          wb_waddr_d = ex_mem_regfile_waddr;
          wb_wdata_d = ex_alu_result;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          if (!req_q.is_store) begin
            wb_we_d    = req_q.rf_we;
            wb_waddr_d = req_q.waddr;
            wb_wdata_d = ld_val;
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem_req             = busy & ~rst;
  assign dmem_we              = busy & ~rst & req_q.is_store;
  assign dmem_addr            = {req_q.addr[31:2], 2'b00};
  assign dmem_be              = req_q.be;
  assign dmem_wdata           = req_q.wdata;
  assign mem_stall            = ~rst & ((~busy & access) | (busy & ~dmem_ack & ~timeout_hit));
  assign mem_wb_regfile_we    = wb_we_q;
  assign mem_wb_regfile_waddr = wb_waddr_q;
  assign mem_wb_wdata         = wb_wdata_q;
  assign mem_addr_err         = addr_err_q;
  assign mem_bus_err          = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_re, ex_mem_we, ex_mem_load_signed, ex_mem_regfile_we;
  logic [31:0] ex_mem_mem_addr, ex_mem_store_data, ex_alu_result;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_mem_regfile_waddr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, mem_wb_regfile_we, mem_addr_err, mem_bus_err;
  logic [4:0]  mem_wb_regfile_waddr;
  logic [31:0] mem_wb_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_mem_mem_addr(ex_mem_mem_addr), .ex_mem_store_data(ex_mem_store_data),
    .ex_mem_size(ex_mem_size), .ex_mem_load_signed(ex_mem_load_signed),
    .ex_alu_result(ex_alu_result), .ex_mem_regfile_we(ex_mem_regfile_we),
    .ex_mem_regfile_waddr(ex_mem_regfile_waddr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .mem_wb_regfile_we(mem_wb_regfile_we), .mem_wb_regfile_waddr(mem_wb_regfile_waddr),
    .mem_wb_wdata(mem_wb_wdata),
    .mem_addr_err(mem_addr_err), .mem_bus_err(mem_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (arithmetic view of the rules) ----------
  function automatic bit m_legal(bit re, bit we, logic [1:0] size, logic [31:0] addr);
    int a;
    a = int'(addr % 32'd4);
    if (re == we) return 1'b0;
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return a == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(bit we, logic [1:0] size, logic [31:0] addr);
    int a;
    a = int'(addr % 32'd4);
    if (!we) return 4'hF;
    case (size)
      2'd0:    return 4'(1 << a);
      2'd1:    return (a >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_st(logic [1:0] size, logic [31:0] d);
    case (size)
      2'd0:    return (d & 32'hFF) * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(logic [1:0] size, logic [31:0] addr, bit sgn, logic [31:0] rd);
    logic [31:0] v;
    int a;
    a = int'(addr % 32'd4);
    case (size)
      2'd0: begin
        v = (rd >> (8 * a)) & 32'hFF;
        if (sgn && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = (rd >> (16 * (a / 2))) & 32'hFFFF;
        if (sgn && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------------------------------
  task automatic idle_inputs();
    ex_mem_re = 0; ex_mem_we = 0; ex_mem_mem_addr = 0; ex_mem_store_data = 0;
    ex_mem_size = 2'd2; ex_mem_load_signed = 0; ex_alu_result = 0;
    ex_mem_regfile_we = 0; ex_mem_regfile_waddr = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Presents one EX operation at posedge+1 and returns at posedge+1 of the
  // cycle in which the next operation may be presented. ack_k >= TO means no ack.
  task automatic run_txn(input bit re, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit sgn, input logic [31:0] d,
                         input logic [31:0] alu, input bit rfwe, input logic [4:0] wa,
                         input int ack_k, input logic [31:0] rdata,
                         output int stall_n, output logic [31:0] wb_obs);
    bit legal, ismem, exp_stall, done;
    int k;
    legal = m_legal(re, we, size, addr);
    ismem = re | we;
    stall_n = 0;
    ex_mem_re = re; ex_mem_we = we; ex_mem_mem_addr = addr; ex_mem_size = size;
    ex_mem_load_signed = sgn; ex_mem_store_data = d; ex_alu_result = alu;
    ex_mem_regfile_we = rfwe; ex_mem_regfile_waddr = wa; dmem_ack = 0;
    #2;
    n_checks++; if (mem_stall !== legal) begin n_fail++; $display("FAIL present_stall got=%b exp=%b", mem_stall, legal); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL present_req got=%b exp=0", dmem_req); end
    if (mem_stall) stall_n++;
    @(posedge clk); #1;
    if (!ismem) begin
      n_checks++; if (mem_wb_regfile_we !== rfwe) begin n_fail++; $display("FAIL alu_we got=%b exp=%b", mem_wb_regfile_we, rfwe); end
      n_checks++; if (mem_wb_regfile_waddr !== wa) begin n_fail++; $display("FAIL alu_waddr got=%0d exp=%0d", mem_wb_regfile_waddr, wa); end
      n_checks++; if (mem_wb_wdata !== alu) begin n_fail++; $display("FAIL alu_wdata got=%h exp=%h", mem_wb_wdata, alu); end
      n_checks++; if ({mem_addr_err, mem_bus_err} !== 2'b00) begin n_fail++; $display("FAIL alu_errs got=%b exp=00", {mem_addr_err, mem_bus_err}); end
      wb_obs = mem_wb_wdata;
      idle_inputs();
      return;
    end
    if (!legal) begin
      n_checks++; if (mem_addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_pulse got=%b exp=1", mem_addr_err); end
      n_checks++; if (mem_wb_regfile_we !== 1'b0) begin n_fail++; $display("FAIL addr_err_we got=%b exp=0", mem_wb_regfile_we); end
      n_checks++; if (mem_bus_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_bus got=%b exp=0", mem_bus_err); end
      wb_obs = mem_wb_wdata;
      idle_inputs();
      #2;
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL addr_err_req got=%b exp=0", dmem_req); end
      @(posedge clk); #1;
      n_checks++; if (mem_addr_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_width got=%b exp=0", mem_addr_err); end
      return;
    end
    n_checks++; if ({mem_wb_regfile_we, mem_addr_err, mem_bus_err} !== 3'b000) begin n_fail++; $display("FAIL accept_outs got=%b exp=000", {mem_wb_regfile_we, mem_addr_err, mem_bus_err}); end
    k = 0; done = 0;
    while (!done) begin
      // A stalled EX may hold anything; the unit must work from its own copy.
      ex_mem_re = 1'($urandom); ex_mem_we = 1'($urandom); ex_mem_mem_addr = $urandom;
      ex_mem_size = 2'($urandom); ex_mem_store_data = $urandom; ex_alu_result = $urandom;
      ex_mem_regfile_we = 1'($urandom); ex_mem_regfile_waddr = 5'($urandom);
      dmem_ack = (k == ack_k);
      dmem_rdata = dmem_ack ? rdata : $urandom;
      #2;
      exp_stall = !((k == ack_k) || (k == TO - 1));
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL busy_req k=%0d got=%b exp=1", k, dmem_req); end
      n_checks++; if (dmem_we !== we) begin n_fail++; $display("FAIL busy_we got=%b exp=%b", dmem_we, we); end
      n_checks++; if (dmem_addr !== (addr & ~32'h3)) begin n_fail++; $display("FAIL busy_addr got=%h exp=%h", dmem_addr, addr & ~32'h3); end
      n_checks++; if (dmem_be !== m_be(we, size, addr)) begin n_fail++; $display("FAIL busy_be got=%b exp=%b", dmem_be, m_be(we, size, addr)); end
      if (we) begin
        n_checks++; if (dmem_wdata !== m_st(size, d)) begin n_fail++; $display("FAIL busy_wdata got=%h exp=%h", dmem_wdata, m_st(size, d)); end
      end
      n_checks++; if (mem_stall !== exp_stall) begin n_fail++; $display("FAIL busy_stall k=%0d got=%b exp=%b", k, mem_stall, exp_stall); end
      n_checks++; if (mem_wb_regfile_we !== 1'b0) begin n_fail++; $display("FAIL busy_wb_we got=%b exp=0", mem_wb_regfile_we); end
      if (mem_stall) stall_n++;
      @(posedge clk); #1;
      done = (k == ack_k) || (k == TO - 1);
      k++;
    end
    idle_inputs();
    if (ack_k < TO) begin
      if (!we) begin
        n_checks++; if (mem_wb_regfile_we !== rfwe) begin n_fail++; $display("FAIL ld_we got=%b exp=%b", mem_wb_regfile_we, rfwe); end
        n_checks++; if (mem_wb_regfile_waddr !== wa) begin n_fail++; $display("FAIL ld_waddr got=%0d exp=%0d", mem_wb_regfile_waddr, wa); end
        n_checks++; if (mem_wb_wdata !== m_ld(size, addr, sgn, rdata)) begin n_fail++; $display("FAIL ld_wdata got=%h exp=%h", mem_wb_wdata, m_ld(size, addr, sgn, rdata)); end
      end else begin
        n_checks++; if ({mem_wb_regfile_we, mem_wb_wdata} !== 33'd0) begin n_fail++; $display("FAIL st_wb got we=%b wdata=%h exp 0/0", mem_wb_regfile_we, mem_wb_wdata); end
      end
      n_checks++; if (mem_bus_err !== 1'b0) begin n_fail++; $display("FAIL done_bus_err got=%b exp=0", mem_bus_err); end
    end else begin
      n_checks++; if (mem_bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err got=%b exp=1", mem_bus_err); end
      n_checks++; if (mem_wb_regfile_we !== 1'b0) begin n_fail++; $display("FAIL to_wb_we got=%b exp=0", mem_wb_regfile_we); end
    end
    wb_obs = mem_wb_wdata;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    ex_mem_re = 1; ex_mem_mem_addr = 32'h40; ex_mem_size = 2'd2; dmem_ack = 1;
    #2;
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", mem_stall); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (mem_wb_regfile_we !== 1'b0) begin n_fail++; $display("FAIL rst_wb_we got=%b exp=0", mem_wb_regfile_we); end
    n_checks++; if (mem_wb_regfile_waddr !== 5'd0) begin n_fail++; $display("FAIL rst_waddr got=%0d exp=0", mem_wb_regfile_waddr); end
    n_checks++; if (mem_wb_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got=%h exp=0", mem_wb_wdata); end
    n_checks++; if ({mem_addr_err, mem_bus_err} !== 2'b00) begin n_fail++; $display("FAIL rst_errs got=%b exp=00", {mem_addr_err, mem_bus_err}); end
    n_checks++; if ({mem_stall, dmem_req} !== 2'b00) begin n_fail++; $display("FAIL rst_held got=%b exp=00", {mem_stall, dmem_req}); end
    rst = 0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    int sn; logic [31:0] wb;
    run_txn(1, 0, 32'h100, 2'd2, 0, 32'h0, 32'h0, 1, 5'd3, 3, 32'hDEADBEEF, sn, wb);
    n_checks++; if (sn != 4) begin n_fail++; $display("FAIL word_load_stall_cycles got=%0d exp=4", sn); end
    n_checks++; if (wb !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_load_wdata got=%h exp=deadbeef", wb); end
    n_checks++; if (mem_wb_regfile_we !== 1'b1) begin n_fail++; $display("FAIL word_load_we got=%b exp=1", mem_wb_regfile_we); end
  endtask

  task automatic test_byte_load();
    int sn; logic [31:0] wb;
    run_txn(1, 0, 32'h103, 2'd0, 1, 32'h0, 32'h0, 1, 5'd4, 0, 32'h80112233, sn, wb);
    n_checks++; if (wb !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_load_signed got=%h exp=ffffff80", wb); end
    n_checks++; if (sn != 1) begin n_fail++; $display("FAIL byte_load_min_latency got=%0d exp=1", sn); end
    run_txn(1, 0, 32'h103, 2'd0, 0, 32'h0, 32'h0, 1, 5'd4, 1, 32'h80112233, sn, wb);
    n_checks++; if (wb !== 32'h00000080) begin n_fail++; $display("FAIL byte_load_unsigned got=%h exp=00000080", wb); end
  endtask

  task automatic test_half_store();
    ex_mem_we = 1; ex_mem_mem_addr = 32'h202; ex_mem_size = 2'd1;
    ex_mem_store_data = 32'h1234ABCD; ex_mem_regfile_we = 1; ex_mem_regfile_waddr = 5'd9;
    #2;
    n_checks++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL hs_accept_stall got=%b exp=1", mem_stall); end
    @(posedge clk); #1;
    idle_inputs();
    dmem_ack = 1;
    #2;
    n_checks++; if ({dmem_req, dmem_we} !== 2'b11) begin n_fail++; $display("FAIL hs_req_we got=%b exp=11", {dmem_req, dmem_we}); end
    n_checks++; if (dmem_addr !== 32'h200) begin n_fail++; $display("FAIL hs_addr got=%h exp=00000200", dmem_addr); end
    n_checks++; if (dmem_be !== 4'b1100) begin n_fail++; $display("FAIL hs_be got=%b exp=1100", dmem_be); end
    n_checks++; if (dmem_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL hs_wdata got=%h exp=abcdabcd", dmem_wdata); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL hs_ack_stall got=%b exp=0", mem_stall); end
    @(posedge clk); #1;
    dmem_ack = 0;
    n_checks++; if (mem_wb_regfile_we !== 1'b0) begin n_fail++; $display("FAIL hs_wb_we got=%b exp=0", mem_wb_regfile_we); end
    n_checks++; if (mem_wb_wdata !== 32'd0) begin n_fail++; $display("FAIL hs_wb_wdata got=%h exp=0", mem_wb_wdata); end
  endtask

  task automatic test_addr_err_alu();
    int sn; logic [31:0] wb;
    run_txn(1, 0, 32'h101, 2'd2, 0, 32'h0, 32'h0, 1, 5'd5, 0, 32'h0, sn, wb);
    n_checks++; if (sn != 0) begin n_fail++; $display("FAIL misalign_stall got=%0d exp=0", sn); end
    run_txn(1, 1, 32'h100, 2'd2, 0, 32'h0, 32'h0, 1, 5'd5, 0, 32'h0, sn, wb);
    run_txn(0, 1, 32'h100, 2'd3, 0, 32'h0, 32'h0, 1, 5'd5, 0, 32'h0, sn, wb);
    run_txn(0, 0, 32'h0, 2'd2, 0, 32'h0, 32'h5, 1, 5'd6, 0, 32'h0, sn, wb);
    n_checks++; if (wb !== 32'h5) begin n_fail++; $display("FAIL alu_passthrough got=%h exp=00000005", wb); end
  endtask

  task automatic test_idle_ack();
    ex_alu_result = 32'h55; ex_mem_regfile_we = 1; ex_mem_regfile_waddr = 5'd7;
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    #2;
    n_checks++; if ({mem_stall, dmem_req} !== 2'b00) begin n_fail++; $display("FAIL idle_ack_ctl got=%b exp=00", {mem_stall, dmem_req}); end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++; if (mem_wb_wdata !== 32'h55) begin n_fail++; $display("FAIL idle_ack_wdata got=%h exp=00000055", mem_wb_wdata); end
    n_checks++; if (mem_wb_regfile_we !== 1'b1) begin n_fail++; $display("FAIL idle_ack_we got=%b exp=1", mem_wb_regfile_we); end
  endtask

  task automatic test_timeout();
    int sn; logic [31:0] wb;
    run_txn(1, 0, 32'h44, 2'd2, 0, 32'h0, 32'h0, 1, 5'd8, TO, 32'h0, sn, wb);
    n_checks++; if (sn != TO) begin n_fail++; $display("FAIL timeout_stall_cycles got=%0d exp=%0d", sn, TO); end
    #2;
    n_checks++; if ({mem_stall, dmem_req} !== 2'b00) begin n_fail++; $display("FAIL timeout_idle got=%b exp=00", {mem_stall, dmem_req}); end
    @(posedge clk); #1;
    n_checks++; if (mem_bus_err !== 1'b0) begin n_fail++; $display("FAIL bus_err_width got=%b exp=0", mem_bus_err); end
  endtask

  task automatic test_back_to_back();
    int sn; logic [31:0] wb;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] sz; logic [31:0] a; bit w;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom & ~((32'd1 << sz) - 32'd1);
      w  = 1'($urandom);
      run_txn(!w, w, a, sz, 1'($urandom), $urandom, 32'h0, 1, 5'($urandom), 0, $urandom, sn, wb);
      n_checks++; if (sn != 1) begin n_fail++; $display("FAIL b2b_stall i=%0d got=%0d exp=1", i, sn); end
    end
  endtask

  task automatic test_reset_busy();
    ex_mem_re = 1; ex_mem_mem_addr = 32'h40; ex_mem_size = 2'd2; ex_mem_regfile_we = 1;
    ex_mem_regfile_waddr = 5'd11;
    #2;
    n_checks++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL rb_accept got=%b exp=1", mem_stall); end
    @(posedge clk); #1;
    idle_inputs();
    #2;
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rb_busy_req got=%b exp=1", dmem_req); end
    rst = 1;
    #1;
    n_checks++; if ({dmem_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL rb_in_rst got=%b exp=00", {dmem_req, mem_stall}); end
    @(posedge clk); #1;
    rst = 0;
    dmem_ack = 1; dmem_rdata = $urandom;
    #2;
    n_checks++; if ({dmem_req, mem_stall} !== 2'b00) begin n_fail++; $display("FAIL rb_after got=%b exp=00", {dmem_req, mem_stall}); end
    @(posedge clk); #1;
    dmem_ack = 0;
    n_checks++; if ({mem_wb_regfile_we, mem_addr_err, mem_bus_err} !== 3'b000) begin n_fail++; $display("FAIL rb_late_ack got=%b exp=000", {mem_wb_regfile_we, mem_addr_err, mem_bus_err}); end
    n_checks++; if ({mem_wb_regfile_waddr, mem_wb_wdata} !== 37'd0) begin n_fail++; $display("FAIL rb_wb_data got=%h exp=0", {mem_wb_regfile_waddr, mem_wb_wdata}); end
  endtask

  task automatic test_random();
    int sn; logic [31:0] wb;
    for (int i = 0; i < 80; i++) begin
      int kind; bit re, we; logic [1:0] sz; logic [31:0] a;
      kind = $urandom_range(0, 9);
      if (kind <= 1) begin
        re = 0; we = 0; sz = 2'($urandom); a = $urandom;
      end else if (kind <= 7) begin
        we = (kind >= 5); re = !we;
        sz = 2'($urandom_range(0, 2));
        a  = $urandom & ~((32'd1 << sz) - 32'd1);
      end else begin
        re = 1'($urandom); we = 1'($urandom); sz = 2'($urandom); a = $urandom;
      end
      run_txn(re, we, a, sz, 1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom),
              $urandom_range(0, TO), $urandom, sn, wb);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_addr_err_alu();
    test_idle_ack();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
